// File: rtl/ps2_kbd_fifo.sv
// PS/2 keyboard receiver: pin synchroniser, 11-bit frame deserialiser with
// start/stop/odd-parity check, and a show-ahead receive FIFO popped by the CPU.
module ps2_kbd_fifo #(
   parameter int DEPTH   = 8,
   parameter int TIMEOUT = 50000
) (
   input  logic                     clock,
   input  logic                     resetn,
   input  logic                     ps2_clk,
   input  logic                     ps2_data,
   input  logic                     rd_en,
   input  logic                     err_clr,
   output logic [7:0]               data,
   output logic                     ready,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic                     frame_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
   localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RECV  = 2'd1,
      CHECK = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic clk_s1_q, clk_s1_d;
   logic clk_s2_q, clk_s2_d;
   logic clk_hist_q, clk_hist_d;
   logic dat_s1_q, dat_s1_d;
   logic dat_s2_q, dat_s2_d;

   logic [3:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shreg_q, shreg_d;
   logic          parity_q, parity_d;
   logic          stop_q, stop_d;
   logic [TW-1:0] idle_cnt_q, idle_cnt_d;

   logic [7:0]    mem_q [DEPTH];
   logic [7:0]    mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          overflow_q, overflow_d;
   logic          frame_err_q, frame_err_d;

   logic fall;
   logic timed_out;
   logic frame_ok;
   logic full;
   logic pop;
   logic push;
   logic ovf_set;
   logic ferr_set;

   // Idle-high synchroniser chains; history flop gives the falling-edge detect
   always_comb begin
      clk_s1_d   = ps2_clk;
      clk_s2_d   = clk_s1_q;
      clk_hist_d = clk_s2_q;
      dat_s1_d   = ps2_data;
      dat_s2_d   = dat_s1_q;
   end

   assign fall      = clk_hist_q & ~clk_s2_q;
   assign timed_out = (state_q == RECV) && !fall && (idle_cnt_q == TO_LAST);

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (fall && !dat_s2_q) begin
               state_d = RECV;
            end
         end
         RECV: begin
            if (fall && bit_cnt_q == 4'd10) begin
               state_d = CHECK;
            end else if (timed_out) begin
               state_d = IDLE;
            end
         end
         CHECK:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // bit_cnt 1..8 are data bits, 9 is parity, 10 is stop
   always_comb begin
      bit_cnt_d  = bit_cnt_q;
      shreg_d    = shreg_q;
      parity_d   = parity_q;
      stop_d     = stop_q;
      idle_cnt_d = '0;
      case (state_q)
         IDLE: begin
            if (fall && !dat_s2_q) begin
               bit_cnt_d = 4'd1;
            end
         end
         RECV: begin
            if (fall) begin
               bit_cnt_d = bit_cnt_q + 4'd1;
               if (bit_cnt_q <= 4'd8) begin
                  shreg_d = {dat_s2_q, shreg_q[7:1]};
               end else if (bit_cnt_q == 4'd9) begin
                  parity_d = dat_s2_q;
               end else begin
                  stop_d = dat_s2_q;
               end
            end else if (timed_out) begin
               bit_cnt_d = 4'd0;
            end else begin
               idle_cnt_d = idle_cnt_q + 1'b1;
            end
         end
         CHECK: begin
            bit_cnt_d = 4'd0;
         end
         default: begin
            bit_cnt_d = 4'd0;
         end
      endcase
   end

   always_comb begin
      frame_ok = stop_q & (^{shreg_q, parity_q});
      full     = (count_q == FULL_CNT);
      pop      = rd_en & ready;
      push     = 1'b0;
      ovf_set  = 1'b0;
      ferr_set = 1'b0;
      if (state_q == CHECK) begin
         if (!frame_ok) begin
            ferr_set = 1'b1;
         end else if (!full || pop) begin
            push = 1'b1;
         end else begin
            ovf_set = 1'b1;
         end
      end
   end

   // A simultaneous push and pop leaves the occupancy unchanged
   always_comb begin
      mem_d = mem_q;
      if (push) begin
         mem_d[wr_ptr_q] = shreg_q;
      end
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      overflow_d  = ovf_set  | (overflow_q  & ~err_clr);
      frame_err_d = ferr_set | (frame_err_q & ~err_clr);
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         clk_s1_q    <= 1'b1;
         clk_s2_q    <= 1'b1;
         clk_hist_q  <= 1'b1;
         dat_s1_q    <= 1'b1;
         dat_s2_q    <= 1'b1;
         bit_cnt_q   <= 4'd0;
         shreg_q     <= 8'h00;
         parity_q    <= 1'b0;
         stop_q      <= 1'b0;
         idle_cnt_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= 8'h00;
         end
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         clk_s1_q    <= clk_s1_d;
         clk_s2_q    <= clk_s2_d;
         clk_hist_q  <= clk_hist_d;
         dat_s1_q    <= dat_s1_d;
         dat_s2_q    <= dat_s2_d;
         bit_cnt_q   <= bit_cnt_d;
         shreg_q     <= shreg_d;
         parity_q    <= parity_d;
         stop_q      <= stop_d;
         idle_cnt_q  <= idle_cnt_d;
         mem_q       <= mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         frame_err_q <= frame_err_d;
      end
   end

   always_comb begin
      ready     = (count_q != '0);
      data      = ready ? mem_q[rd_ptr_q] : 8'h00;
      count     = count_q;
      overflow  = overflow_q;
      frame_err = frame_err_q;
   end

endmodule

// File: tb/tb_ps2_kbd_fifo.sv
// Self-checking bench for ps2_kbd_fifo: directed and random PS/2 frames checked
// against a queue-based reference of the receive FIFO and sticky flags.
module tb_ps2_kbd_fifo;

   localparam int DEPTH   = 8;
   localparam int TIMEOUT = 300;
   localparam int HALF    = 8;

   logic       clock = 1'b0;
   logic       resetn;
   logic       ps2_clk;
   logic       ps2_data;
   logic       rd_en;
   logic       err_clr;
   logic [7:0] data;
   logic       ready;
   logic [3:0] count;
   logic       overflow;
   logic       frame_err;

   int total = 0;
   int bad   = 0;

   logic [7:0] model_q [$];
   logic       model_ovf;
   logic       model_ferr;

   ps2_kbd_fifo #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clock     (clock),
      .resetn    (resetn),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .rd_en     (rd_en),
      .err_clr   (err_clr),
      .data      (data),
      .ready     (ready),
      .count     (count),
      .overflow  (overflow),
      .frame_err (frame_err)
   );

   always #5 clock = ~clock;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_output(input string tag);
      logic [7:0] exp_data;
      exp_data = (model_q.size() > 0) ? model_q[0] : 8'h00;
      check_val({tag, ".data"},      {24'b0, data},      {24'b0, exp_data});
      check_val({tag, ".ready"},     {31'b0, ready},     {31'b0, (model_q.size() > 0)});
      check_val({tag, ".count"},     {28'b0, count},     32'(model_q.size()));
      check_val({tag, ".overflow"},  {31'b0, overflow},  {31'b0, model_ovf});
      check_val({tag, ".frame_err"}, {31'b0, frame_err}, {31'b0, model_ferr});
   endtask

   // Sends frame bits first..last; pop_in_check pulses rd_en in the CHECK cycle of the stop bit
   task automatic send_bits(input logic [10:0] f, input int first, input int last, input logic pop_in_check);
      for (int i = first; i <= last; i++) begin
         ps2_data = f[i];
         repeat (HALF) @(negedge clock);
         ps2_clk = 1'b0;
         if (i == 10 && pop_in_check) begin
            repeat (3) @(negedge clock);
            rd_en = 1'b1;
            @(negedge clock);
            rd_en = 1'b0;
            repeat (HALF - 4) @(negedge clock);
         end else begin
            repeat (HALF) @(negedge clock);
         end
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
   endtask

   function automatic logic [10:0] make_frame(input logic [7:0] b, input logic par_bad, input logic stop_bit);
      return {stop_bit, ~(^b) ^ par_bad, b, 1'b0};
   endfunction

   // Reference: a frame is accepted iff stop=1 and odd parity; a same-cycle pop frees a full slot
   task automatic apply_stimulus(input logic [7:0] b, input logic par_bad, input logic stop_bit,
                                 input logic pop_in_check);
      logic was_full;
      logic popped;
      send_bits(make_frame(b, par_bad, stop_bit), 0, 10, pop_in_check);
      repeat (6) @(negedge clock);
      was_full = (model_q.size() == DEPTH);
      popped   = pop_in_check && (model_q.size() > 0);
      if (popped) void'(model_q.pop_front());
      if (par_bad || !stop_bit) begin
         model_ferr = 1'b1;
      end else if (!was_full || popped) begin
         model_q.push_back(b);
      end else begin
         model_ovf = 1'b1;
      end
   endtask

   task automatic pop_one();
      rd_en = 1'b1;
      @(negedge clock);
      rd_en = 1'b0;
      if (model_q.size() > 0) void'(model_q.pop_front());
   endtask

   task automatic clear_errors();
      err_clr = 1'b1;
      @(negedge clock);
      err_clr = 1'b0;
      model_ovf  = 1'b0;
      model_ferr = 1'b0;
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      @(negedge clock);
      resetn = 1'b1;
      model_q.delete();
      model_ovf  = 1'b0;
      model_ferr = 1'b0;
   endtask

   initial begin
      logic [7:0] b;
      logic       corrupt;
      logic       stop_bad;
      logic       pic;
      int         npops;

      resetn   = 1'b0;
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      rd_en    = 1'b0;
      err_clr  = 1'b0;
      model_q.delete();
      model_ovf  = 1'b0;
      model_ferr = 1'b0;
      repeat (3) @(negedge clock);
      check_output("reset");
      resetn = 1'b1;
      @(negedge clock);

      apply_stimulus(8'h1C, 1'b0, 1'b1, 1'b0);
      check_output("single_1c");
      pop_one();
      check_output("single_pop");
      pop_one();
      check_output("empty_pop");

      apply_stimulus(8'hF0, 1'b0, 1'b1, 1'b0);
      apply_stimulus(8'h1C, 1'b0, 1'b1, 1'b0);
      check_output("two_bytes");
      pop_one();
      check_output("two_pop1");
      pop_one();

      apply_stimulus(8'h1C, 1'b1, 1'b1, 1'b0);
      check_output("bad_parity");
      apply_stimulus(8'h1C, 1'b0, 1'b0, 1'b0);
      check_output("bad_stop");
      clear_errors();
      check_output("err_clr");
      apply_stimulus(8'h29, 1'b0, 1'b1, 1'b0);
      check_output("after_err_29");
      pop_one();

      for (int i = 1; i <= 9; i++) apply_stimulus(8'(i), 1'b0, 1'b1, 1'b0);
      check_output("overflow_fill");
      for (int i = 0; i < 8; i++) begin
         pop_one();
         check_output("overflow_drain");
      end
      clear_errors();
      for (int i = 1; i <= 8; i++) apply_stimulus(8'(i), 1'b0, 1'b1, 1'b0);
      apply_stimulus(8'h09, 1'b0, 1'b1, 1'b1);
      check_output("full_push_pop");
      for (int i = 0; i < 8; i++) begin
         pop_one();
         check_output("full_drain");
      end

      send_bits(make_frame(8'h3C, 1'b0, 1'b1), 0, 4, 1'b0);
      repeat (TIMEOUT + 20) @(negedge clock);
      apply_stimulus(8'h5A, 1'b0, 1'b1, 1'b0);
      check_output("timeout_5a");
      pop_one();

      apply_stimulus(8'h11, 1'b0, 1'b1, 1'b0);
      apply_stimulus(8'h22, 1'b0, 1'b1, 1'b0);
      apply_stimulus(8'h33, 1'b0, 1'b1, 1'b0);
      send_bits(make_frame(8'hA5, 1'b0, 1'b1), 0, 3, 1'b0);
      do_reset();
      check_output("mid_frame_reset");
      send_bits(make_frame(8'hA5, 1'b0, 1'b1), 4, 10, 1'b0);
      repeat (TIMEOUT + 20) @(negedge clock);
      check_output("stale_frame");
      apply_stimulus(8'h1C, 1'b0, 1'b1, 1'b0);
      check_output("fresh_1c");
      pop_one();

      for (int n = 0; n < 24; n++) begin
         b        = 8'($urandom);
         corrupt  = ($urandom_range(0, 3) == 0);
         stop_bad = corrupt && ($urandom_range(0, 1) == 1);
         pic      = ($urandom_range(0, 5) == 0);
         apply_stimulus(b, corrupt && !stop_bad, !stop_bad, pic);
         check_output("rand_frame");
         npops = $urandom_range(0, 2);
         for (int k = 0; k < npops; k++) begin
            pop_one();
            check_output("rand_pop");
         end
         if ($urandom_range(0, 4) == 0) begin
            clear_errors();
            check_output("rand_clr");
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ps2_kbd_fifo.md
# ps2_kbd_fifo

PS/2 keyboard receiver with a receive FIFO. It sits between the board PS2_CLK/PS2_DATA pins and the CPU data-memory read path, as the memory-mapped keyboard source. It synchronises the PS/2 lines, deserialises 11-bit frames, and checks start, stop and odd parity. Valid scan-code bytes are queued in a show-ahead FIFO, and the CPU pops them with a one-cycle read strobe.

## Interface
- DEPTH, 8, FIFO entries; power of two, at least 2
- TIMEOUT, 50000, idle `clock` cycles mid-frame before the receiver resynchronises (1 ms at 50 MHz)
- clock  in  1  system clock (CLK50MHZ); all logic on rising edge
- resetn  in  1  synchronous, active-low reset
- ps2_clk  in  1  raw PS2_CLK pin, asynchronous
- ps2_data  in  1  raw PS2_DATA pin, asynchronous
- rd_en  in  1  pop strobe; one entry per cycle held high
- err_clr  in  1  clears the sticky error flags
- data  out  8  head-of-FIFO byte, show-ahead; 8'h00 when empty
- ready  out  1  FIFO not empty
- count  out  $clog2(DEPTH)+1  current occupancy
- overflow  out  1  sticky: a valid frame was dropped because the FIFO was full
- frame_err  out  1  sticky: a frame failed the start, stop or parity check

## Operation
- Synchroniser: 2-flop chain on each of ps2_clk and ps2_data, followed by one history flop on the synchronised clock.
- fall = history high and synced clock low. Sample synced data only on fall.
- Receiver states:
  - IDLE: on fall with data 0 → RECV, bit_cnt=1. On fall with data 1 → stay in IDLE (glitch/stop ignored).
  - RECV: each fall shifts the data bit into shreg[7:0] LSB-first (bits 1–8), then the parity bit (bit 9), incrementing bit_cnt. On bit 10 → CHECK.
  - CHECK lasts one cycle. The frame is valid iff stop bit == 1 and ^{data, parity} == 1 (odd parity). The start bit was already checked in IDLE. Return to IDLE.
- Valid frame:
  - Push if not full.
  - If full and rd_en is not high this cycle: drop the byte and set overflow.
- Invalid frame: no push; set frame_err.
- Timeout: idle counter resets on every fall and counts while in RECV. When it reaches TIMEOUT-1, the receiver returns to IDLE and discards the partial frame. No flag is set.
- FIFO:
  - Circular buffer with wr_ptr/rd_ptr of $clog2(DEPTH) bits, wrapping modulo DEPTH; count is tracked separately.
  - Pop when rd_en && ready. rd_en on an empty FIFO is ignored, with no underflow.
  - Push and pop in the same cycle: both take effect and count is unchanged. This holds when full (the push is accepted, no overflow) and when empty (ready, count and data rise as for a push alone).
- err_clr clears overflow and frame_err. If a set event occurs in the same cycle, set wins.
- Reset (including mid-frame):
  - state=IDLE, bit_cnt=0, shreg=0, idle counter=0, synchroniser flops=1 (idle high).
  - Pointers and count=0; data=8'h00, ready=0, count=0, overflow=0, frame_err=0.
  - A partially received frame is discarded.

## Timing
- Pin fall to internal fall: 3 `clock` cycles.
- The stop bit is sampled on the cycle fall is seen. CHECK follows on the next cycle. The pushed byte is visible on data/ready/count on the cycle after CHECK.
- Pop: with rd_en high at edge N, data shows the next entry and count decrements after edge N. With back-to-back rd_en, one byte per cycle.
- All outputs are registered or decoded from registers; there are no combinational paths from the pins.
- PS/2 bit period (60–100 µs) is far greater than 5 cycles, so at most one fall is in flight at a time.

## Test plan
- Send frame 0x1C, parity 0 → after CHECK+1: ready=1, count=1, data=8'h1C. Then rd_en for 1 cycle → ready=0, count=0, data=8'h00.
- Send 0xF0 (parity 1) then 0x1C → count=2, data=8'h F0. Pop → data=8'h1C.
- Send 0x1C with parity 1, then with stop bit 0 → count=0, frame_err=1. Then err_clr → frame_err=0. A following valid 0x29 (parity 0) → data=8'h29.
- DEPTH=8: send bytes 0x01..0x09 with no reads → count=8, overflow=1, data=8'h01. Pop all 8 → last data=8'h08, ready=0. Repeat with rd_en asserted in the 9th frame's CHECK cycle → overflow stays 0, count=8, final byte 0x09 present.
- Send start bit plus 4 data bits, idle ≥ TIMEOUT cycles, then full frame 0x5A (parity 1) → data=8'h5A, frame_err=0.
- Assert resetn=0 for 1 cycle mid-frame with 3 bytes queued → all outputs at reset values. Finish the stale frame → no push (it starts in IDLE mid-stream and garbage is discarded by the checks or timeout). A fresh 0x1C frame is then received correctly.
